mul_seq_32b: RTL and testbench
==============================

# mul_seq_32b

Sequential 32×32 shift-and-add multiplier controller, placed directly upstream of the shared 32-bit adder (Add_32b). Each cycle it drives the adder's A/B/Ctrl operand ports and consumes its sum and carry/overflow flags, so the multiplier adds no adder logic of its own. It produces a 64-bit product after 32 iterations under a start/ready/done handshake.

## Interface
- No parameters. Width is fixed at 32 because the adder is fixed at 32.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only while ready=1
- a  input  32  multiplicand, captured on the accepted start
- b  input  32  multiplier, captured on the accepted start
- sgn  input  1  two's-complement mode, captured on start; present only with MUL_SIGNED_EN
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when the product is final
- product  output  64  working register {p_hi, p_lo}
- add_a  output  32  to adder A
- add_b  output  32  to adder B
- add_ctrl  output  1  to adder Ctrl: 0 = A+B, 1 = A−B
- add_s  input  32  adder sum
- add_cf  input  1  adder carry-out
- add_of  input  1  adder signed overflow

## Operation
- Registers:
  - state ∈ {IDLE, RUN, DONE}
  - mcand[31:0], p_hi[31:0], p_lo[31:0]
  - cnt[4:0]
  - sgn_q (only with MUL_SIGNED_EN)
- IDLE:
  - ready=1.
  - If start=1: mcand←a, p_hi←0, p_lo←b, cnt←0, sgn_q←sgn, go to RUN.
  - Otherwise all registers hold.
- RUN, all combinational this cycle:
  - add_a=p_hi.
  - add_b = p_lo[0] ? mcand : 0.
  - add_ctrl = 1 only when sgn_q=1, cnt=31 and p_lo[0]=1; otherwise 0.
- RUN update:
  - top bit = sgn_q ? (add_s[31] ^ add_of) : add_cf.
  - p_hi ← {top, add_s[31:1]}.
  - p_lo ← {add_s[0], p_lo[31:1]}.
  - cnt ← cnt+1.
  - When cnt=31, go to DONE. cnt wraps to 0 and is not used further.
- DONE:
  - done=1; operand outputs idle; go to IDLE next cycle.
- Operand outputs outside RUN: add_a=0, add_b=0, add_ctrl=0.
- start outside IDLE is ignored, including in DONE. Nothing is queued.
- product holds the final result from DONE through IDLE until the next accepted start. It then changes to {0, b}.
- Adder of zero (p_lo[0]=0) must yield add_cf=0 and add_of=0. The adder guarantees this.

## Timing
- Reset values: state=IDLE, ready=1, done=0, product=0, cnt=0, add_a=0, add_b=0, add_ctrl=0, mcand=0.
- Cycle 0: start accepted.
- Cycles 1–32: RUN.
- Cycle 33: done=1 with the final product.
- Cycle 34: ready=1. A new start is accepted no earlier than cycle 34, giving 34 cycles minimum per operation.
- rst has priority over every event, including the accepted-start cycle and the DONE cycle.
  - Reset during RUN or DONE aborts the operation. The next cycle is IDLE with product=0 and no done pulse.
- Adder path: the adder is combinational, so add_a→add_s→p_hi is a single-cycle path.

## Configuration
- MUL_SIGNED_EN defined:
  - The sgn port exists.
  - sgn=1 gives a two's-complement 64-bit product. The final iteration subtracts, and the shift-in bit uses add_s[31]^add_of.
  - sgn=0 behaves as unsigned.
- MUL_SIGNED_EN undefined:
  - No sgn port; sgn_q is tied to 0 and add_of is unused.
  - Unsigned only; add_ctrl is constantly 0.

## Test plan
- a=3, b=5, start at cycle 0 → done=1 at cycle 33, product=0x00000000_0000000F, ready=1 at cycle 34.
- a=b=0xFFFFFFFF unsigned → product=0xFFFFFFFE_00000001. Carry shift-in is exercised.
- start held high throughout and a changed during RUN → exactly one done per 34 cycles; each product uses the operands captured at acceptance.
- rst=1 for one cycle at RUN cycle 10 → next cycle ready=1, product=0, no done pulse; a following 7×6 → 0x2A.
- MUL_SIGNED_EN: a=0xFFFFFFFE, b=3 → sgn=1 gives 0xFFFFFFFF_FFFFFFFA; sgn=0 gives 0x00000002_FFFFFFFA.
- MUL_SIGNED_EN: a=b=0x80000000, sgn=1 → 0x40000000_00000000; add_ctrl=1 only in RUN cycle 32.

Source files
------------

// File: rtl/mul_seq_32b_if.sv
// mul_seq_32b_if: request/response handshake plus adder operand/result bus
// for the sequential 32x32 multiplier.
//   start/a/b[/sgn] : multiply request (sgn only with MUL_SIGNED_EN)
//   ready/done      : handshake status
//   product         : 64-bit working/result register
//   add_a/add_b/add_ctrl -> shared adder; add_s/add_cf/add_of <- adder
// Optional feature macro: MUL_SIGNED_EN (adds the sgn signal).
interface mul_seq_32b_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MUL_SIGNED_EN
    logic        sgn;
`endif
    logic        ready;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_ctrl;
    logic [31:0] add_s;
    logic        add_cf;
    logic        add_of;

`ifdef MUL_SIGNED_EN
    modport slave (
        input  start, a, b, sgn, add_s, add_cf, add_of,
        output ready, done, product, add_a, add_b, add_ctrl
    );
    modport master (
        output start, a, b, sgn, add_s, add_cf, add_of,
        input  ready, done, product, add_a, add_b, add_ctrl
    );
`else
    modport slave (
        input  start, a, b, add_s, add_cf, add_of,
        output ready, done, product, add_a, add_b, add_ctrl
    );
    modport master (
        output start, a, b, add_s, add_cf, add_of,
        input  ready, done, product, add_a, add_b, add_ctrl
    );
`endif
endinterface

// File: rtl/mul_seq_32b.sv
// mul_seq_32b: shift-and-add 32x32 multiplier controller that borrows an
// external combinational 32-bit adder; 64-bit product in 34 cycles.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mul_seq_32b_if.slave (handshake, product, adder operands/results)
// Optional feature macro: MUL_SIGNED_EN (two's-complement mode via sgn).
module mul_seq_32b (
    input  logic         clk,
    input  logic         rst,
    mul_seq_32b_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    p_hi_q, p_hi_d;
    logic [W-1:0]    p_lo_q, p_lo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            sgn_q;
    logic            top_c;
    logic            last_c;

`ifdef MUL_SIGNED_EN
    logic            sgn_d;
`else
    // Unsigned-only build: sign mode is constant, so the subtract and
    // overflow-based sign extension fold away.
    assign sgn_q = 1'b0;
`endif

    assign last_c = (cnt_q == CW'(W - 1));

    // Shift-in bit: true sign of the sum in signed mode, carry-out otherwise.
    assign top_c = sgn_q ? (bus.add_s[W-1] ^ bus.add_of) : bus.add_cf;

    // Next-state, datapath update and adder operand drive.
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        p_hi_d       = p_hi_q;
        p_lo_d       = p_lo_q;
        cnt_d        = cnt_q;
`ifdef MUL_SIGNED_EN
        sgn_d        = sgn_q;
`endif
        bus.add_a    = '0;
        bus.add_b    = '0;
        bus.add_ctrl = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    p_hi_d  = '0;
                    p_lo_d  = bus.b;
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    sgn_d   = bus.sgn;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.add_a    = p_hi_q;
                bus.add_b    = p_lo_q[0] ? mcand_q : '0;
                // Multiplier MSB carries negative weight in signed mode.
                bus.add_ctrl = sgn_q & last_c & p_lo_q[0];
                p_hi_d       = {top_c, bus.add_s[W-1:1]};
                p_lo_d       = {bus.add_s[0], p_lo_q[W-1:1]};
                cnt_d        = CW'(cnt_q + CW'(1));
                if (last_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
`ifdef MUL_SIGNED_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef MUL_SIGNED_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.product = {p_hi_q, p_lo_q};
endmodule

// File: tb/tb_mul_seq_32b.sv
// Directed self-checking bench for mul_seq_32b, with a behavioural model
// of the shared 32-bit adder closing the operand/result loop.
module tb_mul_seq_32b;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    mul_seq_32b_if bus_if ();

    mul_seq_32b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: ctrl=0 -> A+B, ctrl=1 -> A-B (A + ~B + 1).
    logic [31:0] b_eff;
    logic [32:0] sum_w;
    always_comb begin
        b_eff = bus_if.add_ctrl ? ~bus_if.add_b : bus_if.add_b;
        sum_w = {1'b0, bus_if.add_a} + {1'b0, b_eff} + {32'd0, bus_if.add_ctrl};
    end
    assign bus_if.add_s  = sum_w[31:0];
    assign bus_if.add_cf = sum_w[32];
    assign bus_if.add_of = (bus_if.add_a[31] == b_eff[31]) && (sum_w[31] != bus_if.add_a[31]);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One multiply from an IDLE cycle; returns add_ctrl activity seen in RUN.
    task automatic mul_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic [63:0] exp,
                          output int hits, output int hcyc);
        int cyc;
        hits = 0;
        hcyc = 0;
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
`ifdef MUL_SIGNED_EN
        bus_if.sgn   = sv;
`else
        if (sv) $display("note: %s requests signed mode in an unsigned build", tag);
`endif
        step();
        bus_if.start = 1'b0;
        chk({tag, "_ready_low"}, 64'(bus_if.ready), 64'd0);
        chk({tag, "_prod_init"}, bus_if.product, {32'd0, bv});
        chk({tag, "_add_b_c1"}, 64'(bus_if.add_b), 64'(bv[0] ? av : 32'd0));
        cyc = 1;
        while (!bus_if.done && cyc < 40) begin
            if (bus_if.add_ctrl) begin
                hits++;
                hcyc = cyc;
            end
            step();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_product"}, bus_if.product, exp);
        chk({tag, "_ready_in_done"}, 64'(bus_if.ready), 64'd0);
        step();
        chk({tag, "_ready_after"}, 64'(bus_if.ready), 64'd1);
        chk({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
        chk({tag, "_hold"}, bus_if.product, exp);
    endtask

    initial begin
        int hits;
        int hcyc;
        int n_done;
        int d1_cyc;
        int d2_cyc;
        logic [63:0] d1_prod;
        logic [63:0] d2_prod;
        logic        rdy34;
        logic [63:0] prod35;

        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.a = 32'd0;
        bus_if.b = 32'd0;
`ifdef MUL_SIGNED_EN
        bus_if.sgn = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 64'(bus_if.ready), 64'd1);
        chk("rst_done", 64'(bus_if.done), 64'd0);
        chk("rst_product", bus_if.product, 64'd0);
        chk("rst_add_a", 64'(bus_if.add_a), 64'd0);
        chk("rst_add_b", 64'(bus_if.add_b), 64'd0);
        chk("rst_add_ctrl", 64'(bus_if.add_ctrl), 64'd0);

        // Basic unsigned products
        mul_op("m3x5", 32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, hits, hcyc);
        mul_op("mff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, hits, hcyc);
        chk("mff_no_sub", 64'(hits), 64'd0);

        // start held high, operands change during RUN
        bus_if.start = 1'b1;
        bus_if.a = 32'h10;
        bus_if.b = 32'h20;
        step();
        bus_if.a = 32'd7;
        bus_if.b = 32'd9;
        n_done = 0;
        d1_cyc = 0;
        d2_cyc = 0;
        d1_prod = '0;
        d2_prod = '0;
        rdy34 = 1'b0;
        prod35 = '0;
        for (int c = 2; c <= 67; c++) begin
            step();
            if (bus_if.done) begin
                n_done++;
                if (n_done == 1) begin
                    d1_cyc = c;
                    d1_prod = bus_if.product;
                end else begin
                    d2_cyc = c;
                    d2_prod = bus_if.product;
                end
            end
            if (c == 34) rdy34 = bus_if.ready;
            if (c == 35) prod35 = bus_if.product;
        end
        bus_if.start = 1'b0;
        chk("hold_n_done", 64'(n_done), 64'd2);
        chk("hold_d1_cyc", 64'(d1_cyc), 64'd33);
        chk("hold_d1_prod", d1_prod, 64'h200);
        chk("hold_ready34", 64'(rdy34), 64'd1);
        chk("hold_prod35", prod35, 64'h00000000_00000009);
        chk("hold_d2_cyc", 64'(d2_cyc), 64'd67);
        chk("hold_d2_prod", d2_prod, 64'h3F);
        step();
        chk("hold_idle_ready", 64'(bus_if.ready), 64'd1);

        // Reset at RUN cycle 10 aborts
        bus_if.start = 1'b1;
        bus_if.a = 32'h55;
        bus_if.b = 32'h66;
        step();
        bus_if.start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 64'(bus_if.ready), 64'd1);
        chk("abort_product", bus_if.product, 64'd0);
        chk("abort_done", 64'(bus_if.done), 64'd0);
        chk("abort_add_b", 64'(bus_if.add_b), 64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus_if.done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        mul_op("m7x6", 32'd7, 32'd6, 1'b0, 64'h2A, hits, hcyc);

        // Reset coincident with an accepted start wins
        rst = 1'b1;
        bus_if.start = 1'b1;
        bus_if.a = 32'd9;
        bus_if.b = 32'd9;
        step();
        rst = 1'b0;
        bus_if.start = 1'b0;
        chk("rst_start_ready", 64'(bus_if.ready), 64'd1);
        chk("rst_start_product", bus_if.product, 64'd0);
        step();
        chk("rst_start_idle", 64'(bus_if.ready), 64'd1);

        mul_op("mshift", 32'h12345678, 32'h10, 1'b0, 64'h00000001_23456780, hits, hcyc);

`ifdef MUL_SIGNED_EN
        mul_op("s_neg2x3", 32'hFFFFFFFE, 32'd3, 1'b1, 64'hFFFFFFFF_FFFFFFFA, hits, hcyc);
        mul_op("u_neg2x3", 32'hFFFFFFFE, 32'd3, 1'b0, 64'h00000002_FFFFFFFA, hits, hcyc);
        mul_op("s_min2", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, hits, hcyc);
        chk("s_min2_ctrl_hits", 64'(hits), 64'd1);
        chk("s_min2_ctrl_cyc", 64'(hcyc), 64'd32);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
